fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the RISC-V core.
- Owns the program counter and issues word reads to the synchronous instruction ROM (1-cycle read latency).
- Buffers returned instructions with their PC in a small FIFO and delivers them to decode over a valid/ready handshake.
- Adds back-pressure, redirect (branch/jump) with squash of in-flight reads, and a sticky misalignment fault.

Parameters:
- ADDR_W, 16: byte-address width of the PC; the PC wraps modulo 2^ADDR_W.
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2: output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read strobe to instruction ROM
- imem_addr  out  ADDR_W-2  word address, equal to pc[ADDR_W-1:2]
- imem_rdata  in  DATA_W  ROM data, valid one cycle after imem_req
- redirect_valid  in  1  load new PC (branch/jump taken)
- redirect_pc  in  ADDR_W  target byte address
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_instr  out  DATA_W  instruction at FIFO head
- out_pc  out  ADDR_W  byte PC of out_instr
- fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - pc = RESET_PC
  - FIFO empty
  - pending = 0
  - imem_req = 0
  - out_valid = 0
  - fault = 0
  - out_instr and out_pc are don't-care while out_valid = 0.
- Issue:
  - imem_req is combinational.
  - It asserts when !rst, !fault, !redirect_valid, and count + pending - pop < FIFO_DEPTH, where pop = out_valid & out_ready.
  - On issue: pending <= 1, pend_pc <= pc, pc <= pc + 4 (wraps).
- Response:
  - If pending is set and not squashed, the next cycle writes {imem_rdata, pend_pc} into the FIFO.
  - pending clears unless a new issue happens in the same cycle.
- Latency:
  - Request in cycle N; FIFO write at the end of N+1; out_valid high in N+2.
  - After reset release the first request is in cycle 0, so out_valid first rises in cycle 2.
- Throughput: one instruction per cycle while out_ready stays high. The pop credit makes this possible at FIFO_DEPTH = 2.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_instr and out_pc stay stable while out_valid = 1 and out_ready = 0.
  - out_valid never drops without a transfer, except on redirect or reset.
- Redirect (highest priority after rst):
  - In the cycle redirect_valid = 1: no issue; the FIFO is flushed at clock edge; any pending response is discarded (the cycle's imem_rdata is not written); pc <= redirect_pc.
  - A handshake in the same cycle counts as consumed by decode, but the FIFO is still flushed.
  - The first request to the target happens the next cycle, and its out_valid follows 2 cycles after that.
- Misalignment:
  - If redirect_valid and redirect_pc[1:0] != 0: fault <= 1 and pc <= redirect_pc.
  - Issue stops; the FIFO is flushed as for a normal redirect.
  - Fault clears only on rst or on an aligned redirect; that redirect resumes fetch normally in the next cycle.
- Full FIFO: no issue; pc holds. An in-flight response always has a reserved slot, so no overflow is possible by construction.
- Wrap-around: pc = 2^ADDR_W - 4 increments to 0; no flag.
- Reset mid-operation: rst overrides redirect and handshake; the FIFO is emptied and the pending read discarded.

Decomposition:
- Package `fetch_pkg`:
  - INSTR_BYTES = 4
  - PC_ALIGN_BITS = 2
  - RV_NOP = 32'h0000_0013 (bench filler)
  - A FIFO entry struct/width {pc, instr}
- Sub-module: `sync_fifo`, parametrised by width and depth.
  - Provides push, pop, flush, count, and first-word-fall-through head.
  - It is reused later for the decode/execute buffers.

Test Plan:
- Reset, then out_ready = 1 for 6 cycles with ROM word k = 0x1000_0000 + k → out_valid first in cycle 2; out_pc = 0, 4, 8, … on consecutive cycles with matching instr; imem_req high every cycle.
- Back-pressure: out_ready = 0 from cycle 3 to cycle 8 → FIFO fills to 2; imem_req low; out_pc holds at 4 with the instr stable; on release, sequence 4, 8, 12 continues with no gap or duplicate.
- Redirect to 0x0040 while a read is pending and the FIFO is non-empty → next out_valid shows out_pc = 0x0040 exactly 3 cycles after redirect; no stale PC ever appears.
- Misaligned redirect_pc = 0x0042 → fault = 1 next cycle; imem_req stays 0 and out_valid = 0; a later redirect to 0x0080 → fault = 0, fetch resumes at 0x0080.
- RESET_PC = 0xFFF8 with ADDR_W = 16 → out_pc sequence FFF8, FFFC, 0000, 0004.
- Assert rst for one cycle mid-stream with the FIFO full → out_valid = 0 next cycle; restart at RESET_PC with the 2-cycle latency.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its helpers.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam int unsigned PC_ALIGN_BITS = 2;
    localparam logic [31:0] RV_NOP        = 32'h0000_0013;

    // FIFO entry layout for the default 16-bit PC / 32-bit instruction build.
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [PC_ALIGN_BITS-1:0] low_bits);
        return low_bits != '0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, flush and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues ROM reads and buffers {pc, instr}
// for decode, with redirect/squash and a sticky misaligned-redirect fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W     = 16,
    parameter int unsigned         DATA_W     = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter int unsigned         FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [ADDR_W-3:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rdata,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic                         fault
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic               pending_q, pending_d;
    logic               fault_q, fault_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     occupancy;

    assign pop       = out_valid & out_ready;
    // Slots committed next cycle: buffered + in-flight, minus the one decode takes now.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(pending_q) - (CNT_W+1)'(pop);
    assign issue     = ~rst & ~fault_q & ~redirect_valid
                     & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign push      = pending_q & ~redirect_valid;

    assign imem_req  = issue;
    assign imem_addr = pc_q[ADDR_W-1:PC_ALIGN_BITS];
    assign out_valid = ~fifo_empty;
    assign out_instr = fifo_head[DATA_W-1:0];
    assign out_pc    = fifo_head[ENTRY_W-1:DATA_W];
    assign fault     = fault_q;

    always_comb begin
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pending_d = issue;
        fault_d   = fault_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = is_misaligned(redirect_pc[PC_ALIGN_BITS-1:0]);
        end else if (issue) begin
            pc_d      = pc_q + ADDR_W'(INSTR_BYTES);
            pend_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pending_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pending_q <= pending_d;
            fault_q   <= fault_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({pend_pc_q, imem_rdata}),
        .pop       (pop),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transfer scoreboard; a second instance
// starts near the top of the address space to exercise PC wrap-around.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        imem_req, imem_req2;
    logic [13:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        redirect_valid2;
    logic [15:0] redirect_pc2;
    logic        out_valid, out_valid2;
    logic        out_ready, out_ready2;
    logic [31:0] out_instr, out_instr2;
    logic [15:0] out_pc, out_pc2;
    logic        fault, fault2;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q  [$];
    logic [15:0] exp_q2 [$];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault)
    );

    fetch_unit #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'hFFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc(out_pc2), .fault(fault2)
    );

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return 32'h1000_0000 + {18'd0, a};
    endfunction

    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? rom_word(imem_addr)  : RV_NOP;
        imem_rdata2 <= imem_req2 ? rom_word(imem_addr2) : RV_NOP;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every accepted transfer must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [15:0] epc;
                epc = exp_q.pop_front();
                check("xfer_pc", 64'(out_pc), 64'(epc));
                check("xfer_instr", 64'(out_instr), 64'(rom_word(epc[15:2])));
            end
        end
        if (!rst2 && out_valid2 && out_ready2) begin
            check("wrap_expected", 64'(exp_q2.size() != 0), 64'd1);
            if (exp_q2.size() != 0) begin
                logic [15:0] epc2;
                epc2 = exp_q2.pop_front();
                check("wrap_pc", 64'(out_pc2), 64'(epc2));
                check("wrap_instr", 64'(out_instr2), 64'(rom_word(epc2[15:2])));
            end
        end
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        redirect_valid2 = 1'b0; redirect_pc2 = '0;
        out_ready = 1'b0; out_ready2 = 1'b0;
        step(); step();
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_wrap_valid", 64'(out_valid2), 64'd0);
        step();

        // Streaming with decode always ready; cycle 0 is the first out of reset.
        rst = 1'b0; rst2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0008); exp_q.push_back(16'h000C);
        exp_q2.push_back(16'hFFF8); exp_q2.push_back(16'hFFFC);
        exp_q2.push_back(16'h0000); exp_q2.push_back(16'h0004);
        for (int unsigned c = 0; c < 6; c++) begin
            #1;
            check("stream_req", 64'(imem_req), 64'd1);
            check("stream_valid", 64'(out_valid), 64'(c >= 2));
            check("wrap_valid", 64'(out_valid2), 64'(c >= 2));
            step();
        end

        // Back-pressure, cycles 6..11.
        out_ready = 1'b0; out_ready2 = 1'b0;
        for (int unsigned c = 6; c < 12; c++) begin
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_pc", 64'(out_pc), 64'h10);
            check("bp_instr", 64'(out_instr), 64'(rom_word(14'd4)));
            check("bp_req", 64'(imem_req), 64'd0);
            step();
        end

        // Release, cycles 12..15.
        out_ready = 1'b1;
        exp_q.push_back(16'h0010); exp_q.push_back(16'h0014);
        exp_q.push_back(16'h0018); exp_q.push_back(16'h001C);
        #1;
        check("release_req", 64'(imem_req), 64'd1);
        step(); step(); step(); step();

        // Redirect with a read in flight and the FIFO occupied, cycle 16.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        #1;
        check("redir_req", 64'(imem_req), 64'd0);
        check("redir_sb_drained", 64'(exp_q.size()), 64'd0);
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.push_back(16'h0040); exp_q.push_back(16'h0044); exp_q.push_back(16'h0048);
        #1;
        check("redir_issue", 64'(imem_req), 64'd1);
        check("redir_addr", 64'(imem_addr), 64'h10);
        check("redir_valid_c1", 64'(out_valid), 64'd0);
        step();
        #1;
        check("redir_valid_c2", 64'(out_valid), 64'd0);
        step();
        #1;
        check("redir_valid_c3", 64'(out_valid), 64'd1);
        check("redir_pc_c3", 64'(out_pc), 64'h40);
        step(); step(); step();

        // Misaligned redirect, cycle 22.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0042;
        step();
        redirect_valid = 1'b0;
        for (int unsigned c = 23; c < 26; c++) begin
            #1;
            check("fault_set", 64'(fault), 64'd1);
            check("fault_req", 64'(imem_req), 64'd0);
            check("fault_valid", 64'(out_valid), 64'd0);
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        #1;
        check("recover_redir_req", 64'(imem_req), 64'd0);
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.push_back(16'h0080); exp_q.push_back(16'h0084);
        #1;
        check("fault_clear", 64'(fault), 64'd0);
        check("recover_req", 64'(imem_req), 64'd1);
        check("recover_addr", 64'(imem_addr), 64'h20);
        step();
        #1;
        check("recover_valid_c1", 64'(out_valid), 64'd0);
        step();
        #1;
        check("recover_valid_c2", 64'(out_valid), 64'd1);
        check("recover_pc", 64'(out_pc), 64'h80);
        step(); step();

        // Fill the FIFO, then reset mid-stream.
        out_ready = 1'b0;
        step(); step(); step();
        #1;
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_req", 64'(imem_req), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_req", 64'(imem_req), 64'd0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0004);
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_req_after", 64'(imem_req), 64'd1);
        check("midrst_addr", 64'(imem_addr), 64'h0);
        step();
        #1;
        check("midrst_valid_c1", 64'(out_valid), 64'd0);
        step();
        #1;
        check("midrst_valid_c2", 64'(out_valid), 64'd1);
        check("midrst_pc", 64'(out_pc), 64'h0);
        step(); step();
        out_ready = 1'b0;
        step();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("wrap_sb_empty", 64'(exp_q2.size()), 64'd0);
        check("wrap_fault", 64'(fault2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
